// File: rtl/pc_step_sequencer.sv
// Program-counter sequencer: advances pc on rising edges of advance, with branch/jump targets,
// a one-deep stall-pending update, single-step tokens and a saturating retired counter.
module pc_step_sequencer #(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       RESET_VEC = '0,
    parameter int unsigned             STEP      = 1,
    parameter int unsigned             COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_mode,
    input  logic               step_btn,
    input  logic               advance,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_off,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               pc_valid,
    output logic               step_ready,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    state_t              state;
    logic                advance_q;
    logic                step_btn_q;
    logic                token;
    logic [ADDR_W-1:0]   pend_pc;
    logic                adv_edge;
    logic                stp_edge;
    logic                grant;
    logic signed [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0]   next_pc;

    assign adv_edge = advance & ~advance_q;
    assign stp_edge = step_btn & ~step_btn_q;
    assign grant    = adv_edge & (state == IDLE) & (run_mode | token);
    assign off_s    = branch_off;

    // Offset is two's complement; the add wraps mod 2^ADDR_W either way.
    always_comb begin
        next_pc = pc + STEP_V;
        if (jump_en)
            next_pc = jump_target;
        else if (branch_en)
            next_pc = pc + STEP_V + $unsigned(off_s);
    end

    assign pc_valid   = (state == IDLE);
    assign step_ready = ~token;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_VEC;
            retired    <= '0;
            token      <= 1'b0;
            advance_q  <= 1'b1;
            step_btn_q <= 1'b1;
        end else begin
            advance_q  <= advance;
            step_btn_q <= step_btn;

            // A press coinciding with a grant wins, so the new press is not lost.
            if (run_mode)
                token <= 1'b0;
            else if (stp_edge)
                token <= 1'b1;
            else if (grant)
                token <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant && stall) begin
                        state <= PENDING;
                    end else if (grant) begin
                        pc      <= next_pc;
                        retired <= sat_inc(retired);
                    end
                end
                PENDING: begin
                    if (!stall) begin
                        pc      <= pend_pc;
                        retired <= sat_inc(retired);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Parked target is pure data; only the state flag qualifies it.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant && stall)
            pend_pc <= next_pc;
    end

endmodule

// File: tb/tb_pc_step_sequencer.sv
// Directed bench for pc_step_sequencer: two instances share stimulus, one with RESET_VEC=0 and a
// 16-bit counter, one with RESET_VEC=0x00400000 and a 2-bit counter to exercise saturation.
module tb_pc_step_sequencer;

    logic        clk = 1'b0;
    logic        reset, run_mode, step_btn, advance, stall, branch_en, jump_en;
    logic [31:0] branch_off, jump_target;
    logic [31:0] pc_a, pc_b;
    logic        vld_a, vld_b, rdy_a, rdy_b;
    logic [15:0] ret_a;
    logic [1:0]  ret_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_step_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(1), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn), .advance(advance),
        .stall(stall), .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
        .jump_target(jump_target), .pc(pc_a), .pc_valid(vld_a), .step_ready(rdy_a),
        .retired(ret_a)
    );

    pc_step_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0040_0000), .STEP(1), .COUNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn), .advance(advance),
        .stall(stall), .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
        .jump_target(jump_target), .pc(pc_b), .pc_valid(vld_b), .step_ready(rdy_b),
        .retired(ret_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; run_mode = 1'b1; step_btn = 1'b0; advance = 1'b1; stall = 1'b0;
        branch_en = 1'b0; jump_en = 1'b0; branch_off = '0; jump_target = '0;
        #1;
        tick(); tick();
        check("rst_pc_b", pc_b, 32'h0040_0000);
        check("rst_pc_a", pc_a, 32'h0);
        check("rst_valid", {31'b0, vld_b}, 32'd1);
        check("rst_ready", {31'b0, rdy_b}, 32'd1);
        check("rst_retired", {30'b0, ret_b}, 32'd0);

        // advance held high through reset must not count as an edge
        reset = 1'b0;
        tick(); tick();
        check("held_adv_pc", pc_b, 32'h0040_0000);
        check("held_adv_ret", {16'b0, ret_a}, 32'd0);
        advance = 1'b0;
        tick();

        // sequential run, latency one cycle
        advance = 1'b1;
        #1 check("seq_before_edge", pc_a, 32'd0);
        tick();
        check("seq1", pc_a, 32'd1);
        advance = 1'b0;
        tick();
        pulse(); check("seq2", pc_a, 32'd2);
        pulse(); check("seq3", pc_a, 32'd3);
        check("seq_ret", {16'b0, ret_a}, 32'd3);
        check("seq_pc_b", pc_b, 32'h0040_0003);

        // negative branch, then jump priority over branch
        branch_en = 1'b1; branch_off = 32'hFFFF_FFFE;
        pulse(); check("branch_back", pc_a, 32'd2);
        jump_en = 1'b1; jump_target = 32'h100;
        pulse(); check("jump_prio", pc_a, 32'h100);
        branch_en = 1'b0; jump_en = 1'b0;
        check("ret5", {16'b0, ret_a}, 32'd5);

        // single-step mode
        run_mode = 1'b0;
        tick();
        pulse(); pulse();
        check("step_no_press", pc_a, 32'h100);
        step_btn = 1'b1; tick();
        check("step_rdy_low", {31'b0, rdy_a}, 32'd0);
        step_btn = 1'b0; tick();
        pulse();
        check("step_adv", pc_a, 32'h101);
        check("step_rdy_back", {31'b0, rdy_a}, 32'd1);
        step_btn = 1'b1; tick(); step_btn = 1'b0; tick();
        advance = 1'b1; step_btn = 1'b1; tick();
        check("coinc_pc", pc_a, 32'h102);
        check("coinc_rdy", {31'b0, rdy_a}, 32'd0);
        advance = 1'b0; step_btn = 1'b0; tick();
        pulse();
        check("coinc_kept_pc", pc_a, 32'h103);
        check("coinc_kept_rdy", {31'b0, rdy_a}, 32'd1);

        // stall with pending update
        run_mode = 1'b1;
        tick();
        stall = 1'b1;
        pulse();
        check("stall_pc", pc_a, 32'h103);
        check("stall_valid", {31'b0, vld_a}, 32'd0);
        pulse();
        check("stall_ignored", pc_a, 32'h103);
        stall = 1'b0;
        tick();
        check("unstall_pc", pc_a, 32'h104);
        check("unstall_valid", {31'b0, vld_a}, 32'd1);
        check("unstall_ret", {16'b0, ret_a}, 32'd9);
        tick(); tick();
        check("unstall_once", pc_a, 32'h104);
        check("unstall_ret2", {16'b0, ret_a}, 32'd9);

        // wrap and saturation
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFF;
        pulse(); jump_en = 1'b0;
        check("pc_max", pc_a, 32'hFFFF_FFFF);
        pulse();
        check("pc_wrap", pc_a, 32'h0);
        check("ret_a11", {16'b0, ret_a}, 32'd11);
        check("ret_b_sat", {30'b0, ret_b}, 32'd3);

        // reset while pending
        stall = 1'b1;
        pulse();
        check("pend_before_rst", {31'b0, vld_a}, 32'd0);
        reset = 1'b1; tick();
        check("rst_pend_pc_a", pc_a, 32'h0);
        check("rst_pend_pc_b", pc_b, 32'h0040_0000);
        check("rst_pend_valid", {31'b0, vld_a}, 32'd1);
        check("rst_pend_ret", {16'b0, ret_a}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        tick(); tick();
        check("rst_pend_drop", pc_a, 32'h0);
        check("rst_pend_ret2", {16'b0, ret_a}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
